// File: rtl/canny_color_fuse.sv
// Colour-Canny fusion: delays raw RGB565 by DELAY clocks, then merges it with the DTM edge bit.
// Latency 1 clock from DTM inputs (1+DELAY from rgb565); no backpressure, one pixel per clock.
module canny_color_fuse #(
  parameter int          DELAY      = 15,
  parameter int          AW         = 5,
  parameter logic [15:0] EDGE_COLOR = 16'hFD68
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        rgb565_hs,
  input  logic        rgb565_vs,
  input  logic        rgb565_de,
  input  logic [15:0] rgb565,
  input  logic        DTM_data,
  input  logic        DTM_hs,
  input  logic        DTM_vs,
  input  logic        DTM_de,
  input  logic [1:0]  FUSE_MODE,
  input  logic        clr_err,
  output logic        color_hs,
  output logic        color_vs,
  output logic        color_de,
  output logic [15:0] color_data,
  output logic        align_err
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] DLY   = AW'(DELAY);

  logic [18:0]   buf_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr;
  logic [AW-1:0] fill_q, fill_d;
  logic          fill_done;
  logic [18:0]   rd_ent;
  logic          d_hs, d_vs, d_de;
  logic [15:0]   d_rgb, dim_rgb;
  logic [15:0]   data_d;
  logic          align_err_d;
  logic          color_hs_q, color_vs_q, color_de_q, align_err_q;
  logic [15:0]   color_data_q;
  logic          unused_timing;

  // Buffer storage carries no reset; the fill counter masks stale entries instead.
  always_ff @(posedge video_clk) begin
    buf_q[wptr_q] <= {rgb565_hs, rgb565_vs, rgb565_de, rgb565};
  end

  assign wptr_d    = wptr_q + AW'(1);
  assign rptr      = wptr_q - DLY;
  assign rd_ent    = buf_q[rptr];
  assign fill_done = (fill_q == DLY);
  assign fill_d    = fill_done ? fill_q : fill_q + AW'(1);

  assign {d_hs, d_vs, d_de, d_rgb} = fill_done ? rd_ent : 19'd0;

  // Delayed hs/vs ride along in the buffer but the DTM stream is the timing master.
  assign unused_timing = d_hs ^ d_vs;

  assign dim_rgb = {1'b0, d_rgb[15:12], 1'b0, d_rgb[10:6], 1'b0, d_rgb[4:1]};

  always_comb begin
    data_d = 16'd0;
    if (DTM_de) begin
      case (FUSE_MODE)
        2'd0:    data_d = DTM_data ? EDGE_COLOR : d_rgb;
        2'd1:    data_d = DTM_data ? EDGE_COLOR : dim_rgb;
        2'd2:    data_d = DTM_data ? EDGE_COLOR : 16'd0;
        default: data_d = DTM_data ? d_rgb : 16'd0;
      endcase
    end
  end

  // A fresh mismatch outranks a clear arriving in the same cycle.
  always_comb begin
    align_err_d = align_err_q;
    if (fill_done && (d_de != DTM_de)) align_err_d = 1'b1;
    else if (clr_err)                  align_err_d = 1'b0;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      fill_q       <= '0;
      color_hs_q   <= 1'b0;
      color_vs_q   <= 1'b0;
      color_de_q   <= 1'b0;
      color_data_q <= 16'd0;
      align_err_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      fill_q       <= fill_d;
      color_hs_q   <= DTM_hs;
      color_vs_q   <= DTM_vs;
      color_de_q   <= DTM_de;
      color_data_q <= data_d;
      align_err_q  <= align_err_d;
    end
  end

  assign color_hs   = color_hs_q;
  assign color_vs   = color_vs_q;
  assign color_de   = color_de_q;
  assign color_data = color_data_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_canny_color_fuse.sv
// Directed bench for canny_color_fuse: latency, fill masking, fusion modes, blanking,
// alignment flag behaviour and asynchronous reset mid-frame.
module tb_canny_color_fuse;

  localparam int DELAY = 15;

  logic        video_clk = 1'b0;
  logic        rst_n;
  logic        rgb565_hs, rgb565_vs, rgb565_de;
  logic [15:0] rgb565;
  logic        DTM_data, DTM_hs, DTM_vs, DTM_de;
  logic [1:0]  FUSE_MODE;
  logic        clr_err;
  logic        color_hs, color_vs, color_de;
  logic [15:0] color_data;
  logic        align_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  mode;
    logic        data;
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  canny_color_fuse #(.DELAY(DELAY), .AW(5), .EDGE_COLOR(16'hFD68)) dut (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .rgb565_hs (rgb565_hs),
    .rgb565_vs (rgb565_vs),
    .rgb565_de (rgb565_de),
    .rgb565    (rgb565),
    .DTM_data  (DTM_data),
    .DTM_hs    (DTM_hs),
    .DTM_vs    (DTM_vs),
    .DTM_de    (DTM_de),
    .FUSE_MODE (FUSE_MODE),
    .clr_err   (clr_err),
    .color_hs  (color_hs),
    .color_vs  (color_vs),
    .color_de  (color_de),
    .color_data(color_data),
    .align_err (align_err)
  );

  always #5 video_clk = ~video_clk;

  task automatic step();
    @(posedge video_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lat_val(input int n);
    return 16'(n * 37 + 5);
  endfunction

  task automatic fill_check(input string tag);
    for (int n = 0; n < DELAY + 4; n++) begin
      step();
      chk({tag, "_data"}, 32'(color_data), (n < DELAY) ? 32'h0 : 32'hFFFF);
      chk({tag, "_de"}, 32'(color_de), 32'd1);
    end
  endtask

  initial begin
    vecs[0]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    vecs[1]  = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h7BEF};
    vecs[2]  = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[3]  = '{2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000};
    vecs[4]  = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFD68};
    vecs[5]  = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFD68};
    vecs[6]  = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFD68};
    vecs[7]  = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF};
    vecs[8]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[9]  = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[10] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[11] = '{2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};

    rst_n = 1'b0;
    rgb565_hs = 1'b0; rgb565_vs = 1'b0; rgb565_de = 1'b0; rgb565 = 16'h0;
    DTM_data = 1'b0; DTM_hs = 1'b0; DTM_vs = 1'b0; DTM_de = 1'b0;
    FUSE_MODE = 2'd0; clr_err = 1'b0;
    #2;
    chk("rst_data", 32'(color_data), 32'h0);
    chk("rst_flags", 32'({color_hs, color_vs, color_de, align_err}), 32'h0);
    @(posedge video_clk);
    @(posedge video_clk);
    #3 rst_n = 1'b1;

    // Latency: distinct value per clock, read back DELAY clocks later across the wptr wrap.
    rgb565_de = 1'b1; DTM_de = 1'b1;
    for (int n = 0; n < 50; n++) begin
      rgb565 = lat_val(n);
      step();
      chk("latency", 32'(color_data), (n >= DELAY) ? 32'(lat_val(n - DELAY)) : 32'h0);
    end
    chk("latency_no_err", 32'(align_err), 32'd0);

    // Fresh reset, then constant white stream to observe fill masking.
    @(posedge video_clk);
    #3 rst_n = 1'b0;
    @(posedge video_clk);
    #3 rst_n = 1'b1;
    rgb565 = 16'hFFFF;
    fill_check("fill");

    foreach (vecs[i]) begin
      FUSE_MODE = vecs[i].mode;
      DTM_data  = vecs[i].data;
      DTM_de    = vecs[i].de;
      DTM_hs    = vecs[i].hs;
      DTM_vs    = vecs[i].vs;
      step();
      chk("mode_data", 32'(color_data), 32'(vecs[i].exp));
      chk("mode_timing", 32'({color_hs, color_vs, color_de}),
          32'({vecs[i].hs, vecs[i].vs, vecs[i].de}));
    end

    // Async reset mid-frame; align_err is set from the blanking rows above.
    FUSE_MODE = 2'd0; DTM_data = 1'b0; DTM_de = 1'b1; DTM_hs = 1'b1; DTM_vs = 1'b1;
    step();
    chk("pre_rst_data", 32'(color_data), 32'hFFFF);
    chk("pre_rst_err", 32'(align_err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(color_data), 32'h0);
    chk("async_rst_flags", 32'({color_hs, color_vs, color_de, align_err}), 32'h0);
    @(posedge video_clk);
    #3 rst_n = 1'b1;
    DTM_hs = 1'b0; DTM_vs = 1'b0;
    fill_check("refill");
    chk("refill_no_err", 32'(align_err), 32'd0);

    // Single-clock dip in rgb565_de surfaces as a mismatch DELAY clocks later.
    rgb565_de = 1'b0;
    step();
    rgb565_de = 1'b1;
    chk("align_k", 32'(align_err), 32'd0);
    repeat (DELAY - 2) step();
    step();
    chk("align_pre", 32'(align_err), 32'd0);
    step();
    chk("align_set", 32'(align_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("align_hold", 32'(align_err), 32'd1);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("align_clr", 32'(align_err), 32'd0);
    step();
    chk("align_clr_hold", 32'(align_err), 32'd0);

    // Clear coincident with a new mismatch: set wins.
    rgb565_de = 1'b0;
    step();
    rgb565_de = 1'b1;
    repeat (DELAY - 1) step();
    chk("coinc_pre", 32'(align_err), 32'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("coinc_set_wins", 32'(align_err), 32'd1);
    step();
    chk("coinc_hold", 32'(align_err), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("coinc_clr", 32'(align_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
